id_seg: RTL and testbench



---
 rtl/id_seg.sv | 97 +++++++++
 tb/tb_id_seg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_seg.sv
// id_seg: decode stage with 32x32 register file, write-back port and ID/EX latch.
// Latency: IR_i to ID/EX outputs in 1 cycle; write-back is bypassed into same-cycle reads.
// Backpressure: stall_o (combinational) holds IF for one bubble per load-use hazard.
module id_seg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR_i,
  input  logic [31:0] NPC_i,
  input  logic [31:0] WB_Data,
  input  logic        WB_Write,
  input  logic [4:0]  WB_Addr,
  output logic [31:0] A_o,
  output logic [31:0] B_o,
  output logic [31:0] Imm_o,
  output logic [31:0] IR_o,
  output logic [31:0] NPC_o,
  output logic        stall_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        wb_en;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_val;
  logic        uses_rs;
  logic        uses_rt;
  logic [4:0]  ex_rt;
  logic        ex_is_lw;

  assign op    = IR_i[31:26];
  assign rs    = IR_i[25:21];
  assign rt    = IR_i[20:16];
  assign wb_en = WB_Write && (WB_Addr != 5'd0);

  // Write-first: a write landing this edge is visible to the decode sampled at the same edge.
  always_comb begin
    rs_val = 32'h0;
    rt_val = 32'h0;
    if (rs != 5'd0) rs_val = (wb_en && (WB_Addr == rs)) ? WB_Data : regs[rs];
    if (rt != 5'd0) rt_val = (wb_en && (WB_Addr == rt)) ? WB_Data : regs[rt];
  end

  always_comb begin
    case (op)
      OP_ANDI, OP_ORI: imm_val = {16'h0, IR_i[15:0]};
      OP_J:            imm_val = {6'b0, IR_i[25:0]};
      default:         imm_val = {{16{IR_i[15]}}, IR_i[15:0]};
    endcase
  end

  assign uses_rs  = (op != OP_J);
  assign uses_rt  = (op == OP_RTYPE) || (op == OP_SW);
  assign ex_rt    = IR_o[20:16];
  assign ex_is_lw = (IR_o[31:26] == OP_LW);

  // Hazard looks only at the instruction in EX, never at the write-back port.
  assign stall_o = ex_is_lw && (ex_rt != 5'd0) &&
                   ((uses_rs && (rs == ex_rt)) || (uses_rt && (rt == ex_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      A_o   <= 32'h0;
      B_o   <= 32'h0;
      Imm_o <= 32'h0;
      IR_o  <= 32'h0;
      NPC_o <= 32'h0;
    end else begin
      if (wb_en) regs[WB_Addr] <= WB_Data;
      if (stall_o) begin
        A_o   <= 32'h0;
        B_o   <= 32'h0;
        Imm_o <= 32'h0;
        IR_o  <= 32'h0;
        NPC_o <= 32'h0;
      end else begin
        A_o   <= rs_val;
        B_o   <= rt_val;
        Imm_o <= imm_val;
        IR_o  <= IR_i;
        NPC_o <= NPC_i;
      end
    end
  end

endmodule

// File: tb/tb_id_seg.sv
// Scoreboard bench for id_seg: directed test-plan sequences followed by random traffic,
// checked against an architectural model of the register file and decode rules.
module tb_id_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_i, NPC_i, WB_Data;
  logic        WB_Write;
  logic [4:0]  WB_Addr;
  logic [31:0] A_o, B_o, Imm_o, IR_o, NPC_o;
  logic        stall_o;

  always #5 clk = ~clk;

  id_seg dut (
    .clk(clk), .rst(rst), .IR_i(IR_i), .NPC_i(NPC_i),
    .WB_Data(WB_Data), .WB_Write(WB_Write), .WB_Addr(WB_Addr),
    .A_o(A_o), .B_o(B_o), .Imm_o(Imm_o), .IR_o(IR_o), .NPC_o(NPC_o),
    .stall_o(stall_o)
  );

  typedef struct {
    bit          chk_stall;
    bit          stall;
    logic [31:0] a, b, imm, ir, npc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_ir_o;
  bit          m_known = 0;
  bit          m_last_stall = 0;

  function automatic bit reads_reg(logic [31:0] ir, logic [4:0] r);
    int op = int'(ir[31:26]);
    if (op == 2) return 0;
    if (ir[25:21] == r) return 1;
    if ((op == 0 || op == 43) && ir[20:16] == r) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ext_imm(logic [31:0] ir);
    int          op = int'(ir[31:26]);
    logic [15:0] h  = ir[15:0];
    if (op == 12 || op == 13) return ir & 32'h0000FFFF;
    if (op == 2) return ir & 32'h03FFFFFF;
    return 32'($signed(h));
  endfunction

  function automatic logic [31:0] rd_reg(logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : m_regs[idx];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs (just after a rising edge), updates the model and queues expectations.
  task automatic cyc(bit r, logic [31:0] ir, logic [31:0] npc, bit w, logic [4:0] a, logic [31:0] d);
    exp_t e;
    rst = r; IR_i = ir; NPC_i = npc; WB_Write = w; WB_Addr = a; WB_Data = d;
    e.chk_stall = m_known;
    e.stall = m_known && (m_ir_o[31:26] == 6'h23) && (m_ir_o[20:16] != 5'd0) &&
              reads_reg(ir, m_ir_o[20:16]);
    m_last_stall = e.stall;
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      e.a = 0; e.b = 0; e.imm = 0; e.ir = 0; e.npc = 0;
    end else begin
      if (w && a != 5'd0) m_regs[a] = d;
      if (e.stall) begin
        e.a = 0; e.b = 0; e.imm = 0; e.ir = 0; e.npc = 0;
      end else begin
        e.a = rd_reg(ir[25:21]); e.b = rd_reg(ir[20:16]);
        e.imm = ext_imm(ir); e.ir = ir; e.npc = npc;
      end
    end
    m_ir_o  = e.ir;
    m_known = 1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: stall_o is judged against the cycle being driven now; registered outputs
  // against the oldest queued cycle, which has already passed an edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[$].chk_stall) check("stall_o", {31'h0, stall_o}, {31'h0, q[$].stall});
      if (q.size() >= 2) begin
        exp_t e;
        e = q.pop_front();
        check("A_o", A_o, e.a);
        check("B_o", B_o, e.b);
        check("Imm_o", Imm_o, e.imm);
        check("IR_o", IR_o, e.ir);
        check("NPC_o", NPC_o, e.npc);
      end
    end
  end

  localparam logic [31:0] LW_R2  = 32'h8C020000;
  localparam logic [31:0] ADD_R2 = 32'h00430820;
  localparam logic [31:0] SW_R2  = 32'hACE20000;

  initial begin
    logic [31:0] ir, npc;
    logic [5:0]  ops [9];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h08; ops[4] = 6'h0C;
    ops[5] = 6'h0D; ops[6] = 6'h02; ops[7] = 6'h04; ops[8] = 6'h3F;

    // Reset overrides a pending write to r5
    cyc(1, 32'h0, 32'h0, 1, 5'd5, 32'd99);
    cyc(0, 32'h20A10000, 32'h104, 0, 0, 0);           // addi r1,r5,0: r5 must read 0
    // Bypass, then array read of the same register
    cyc(0, 32'h00640820, 32'h108, 1, 5'd3, 32'd456);
    cyc(0, 32'h00640820, 32'h10C, 0, 0, 0);
    // Writes to r0 are discarded
    cyc(0, 32'h20010000, 32'h110, 1, 5'd0, 32'd123);
    cyc(0, 32'h20010000, 32'h114, 0, 0, 0);
    // Immediate extension
    cyc(0, 32'h2000FFFF, 32'h118, 0, 0, 0);
    cyc(0, 32'h3000FFFF, 32'h11C, 0, 0, 0);
    cyc(0, 32'h0BFFFFFF, 32'h120, 0, 0, 0);
    // Load-use with add, held for the bubble
    cyc(0, LW_R2,  32'h124, 0, 0, 0);
    cyc(0, ADD_R2, 32'h128, 0, 0, 0);
    cyc(0, ADD_R2, 32'h128, 0, 0, 0);
    // Load-use with sw, with a simultaneous write-back to r2
    cyc(0, LW_R2, 32'h12C, 0, 0, 0);
    cyc(0, SW_R2, 32'h130, 1, 5'd2, 32'h55);
    cyc(0, SW_R2, 32'h130, 0, 0, 0);
    // lw r0 never creates a hazard
    cyc(0, 32'h8C000000, 32'h134, 0, 0, 0);
    cyc(0, 32'h00000820, 32'h138, 0, 0, 0);
    // Reset during a stall cycle
    cyc(0, LW_R2,  32'h13C, 1, 5'd7, 32'h77);
    cyc(1, ADD_R2, 32'h140, 0, 0, 0);
    cyc(0, ADD_R2, 32'h140, 0, 0, 0);

    ir = 32'h0; npc = 32'h200;
    for (int n = 0; n < 600; n++) begin
      bit r;
      if (!m_last_stall) begin
        ir = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
        npc = npc + 32'd4;
      end
      r = ($urandom_range(0, 49) == 0);
      cyc(r, ir, npc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    cyc(0, 32'h0, 32'h0, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
